// File: rtl/jk_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_pkg
// Description : Shared types for the JK flip-flop bank arbiter. Defines the
//               2-bit command encoding and its mapping onto a {j,k} pair.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_bank_pkg;

    // Command encoding as seen on req_op; the numeric value equals {j,k}.
    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_t;

    // Returns {j,k} for a command.
    function automatic logic [1:0] op_to_jk(input jk_op_t op);
        logic [1:0] jk;
        case (op)
            OP_CLEAR:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module      : jk_cell
// Description : Single JK flip-flop with synchronous active-high reset.
//               Ports: clk, reset, j, k (inputs); q, q_bar (outputs).
//               j/k: 00 hold, 01 clear, 10 set, 11 toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    // q_bar is derived from the stored bit so it reads all-ones out of reset.
    assign q     = r_q;
    assign q_bar = ~r_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_arbiter
// Description : Round-robin arbiter sharing a bank of NFF JK flip-flops
//               between NREQ requesters. One command is accepted per cycle,
//               registered, and applied to the addressed cell on the next edge.
// Ports       : clk, reset            - clock / sync active-high reset
//               req_valid/ready       - per-requester handshake
//               req_op, req_idx       - per-requester command and target
//               q, q_bar              - bank state and its complement
//               cmd_valid, cmd_gid    - registered command being applied
//               err_idx               - pulse: applied command idx >= NFF
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IDXW = $clog2(NFF),
    parameter int GIDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
    output logic [NFF-1:0]       q,
    output logic [NFF-1:0]       q_bar,
    output logic                 cmd_valid,
    output logic [GIDW-1:0]      cmd_gid,
    output logic                 err_idx
);

    logic [GIDW-1:0] r_rr_ptr;
    logic            r_cmd_valid;
    logic [GIDW-1:0] r_cmd_gid;
    jk_op_t          r_cmd_op;
    logic [IDXW-1:0] r_cmd_idx;
    logic            r_err_idx;

    logic            w_found;
    logic [GIDW-1:0] w_gid;
    logic [GIDW-1:0] w_cand;
    logic            w_cmd_oob;
    logic [NFF-1:0]  w_j;
    logic [NFF-1:0]  w_k;

    // Round-robin search starting at r_rr_ptr; the first valid requester wins.
    // Grants are suppressed in the reset cycle so nothing is handshaken away.
    always_comb begin
        w_found   = 1'b0;
        w_gid     = '0;
        w_cand    = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = GIDW'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gid   = w_cand;
            end
        end
        if (reset) begin
            w_found = 1'b0;
        end
        if (w_found) begin
            req_ready = NREQ'(1) << w_gid;
        end
    end

    // Command register and pointer; an accept is exactly w_found.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_gid   <= '0;
            r_cmd_op    <= OP_HOLD;
            r_cmd_idx   <= '0;
            r_err_idx   <= 1'b0;
        end else begin
            r_cmd_valid <= w_found;
            r_err_idx   <= w_cmd_oob;
            if (w_found) begin
                r_cmd_gid <= w_gid;
                r_cmd_op  <= jk_op_t'(req_op[2*int'(w_gid) +: 2]);
                r_cmd_idx <= req_idx[IDXW*int'(w_gid) +: IDXW];
                r_rr_ptr  <= GIDW'((int'(w_gid) + 1) % NREQ);
            end
        end
    end

    // Out-of-range index is only reachable when NFF is not a power of two.
    assign w_cmd_oob = r_cmd_valid && (int'(r_cmd_idx) >= NFF);

    // Apply stage: only the addressed cell sees the command's j/k.
    always_comb begin
        w_j = '0;
        w_k = '0;
        for (int f = 0; f < NFF; f++) begin
            if (r_cmd_valid && (int'(r_cmd_idx) == f)) begin
                {w_j[f], w_k[f]} = op_to_jk(r_cmd_op);
            end
        end
    end

    generate
        for (genvar g = 0; g < NFF; g++) begin : g_cells
            jk_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (w_j[g]),
                .k     (w_k[g]),
                .q     (q[g]),
                .q_bar (q_bar[g])
            );
        end
    endgenerate

    assign cmd_valid = r_cmd_valid;
    assign cmd_gid   = r_cmd_gid;
    assign err_idx   = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_arbiter
// Description : Directed self-checking bench for jk_bank_arbiter. A second
//               instance with NFF=6 exercises the out-of-range index path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [11:0] req_idx;
    logic [7:0]  q;
    logic [7:0]  q_bar;
    logic        cmd_valid;
    logic [1:0]  cmd_gid;
    logic        err_idx;

    logic [3:0]  req_ready6;
    logic [5:0]  q6;
    logic [5:0]  q_bar6;
    logic        cmd_valid6;
    logic [1:0]  cmd_gid6;
    logic        err_idx6;

    int n_cmp;
    int n_err;

    jk_bank_arbiter #(.NREQ(4), .NFF(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .q         (q),
        .q_bar     (q_bar),
        .cmd_valid (cmd_valid),
        .cmd_gid   (cmd_gid),
        .err_idx   (err_idx)
    );

    jk_bank_arbiter #(.NREQ(4), .NFF(6)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready6),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .q         (q6),
        .q_bar     (q_bar6),
        .cmd_valid (cmd_valid6),
        .cmd_gid   (cmd_gid6),
        .err_idx   (err_idx6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'hF;
        req_op    = 8'hFF;
        req_idx   = '0;
        #1;
        n_cmp++;
        if (req_ready !== 4'h0) begin
            n_err++; $display("FAIL reset_ready: got %h want 0", req_ready);
        end
        tick();
        tick();
        n_cmp++;
        if (q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", q); end
        n_cmp++;
        if (q_bar !== 8'hFF) begin n_err++; $display("FAIL reset_qbar: got %h want ff", q_bar); end
        n_cmp++;
        if (cmd_valid !== 1'b0 || cmd_gid !== 2'd0 || err_idx !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cmd: got v=%b gid=%0d err=%b want 0/0/0", cmd_valid, cmd_gid, err_idx);
        end
        req_valid = '0;
        req_op    = '0;
        reset     = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_valid      = 4'b0010;
        req_op[3:2]    = 2'b10;
        req_idx[5:3]   = 3'd3;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL single_ready: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_gid !== 2'd1 || q !== 8'h00) begin
            n_err++;
            $display("FAIL single_cmd: got v=%b gid=%0d q=%h want 1/1/00", cmd_valid, cmd_gid, q);
        end
        tick();
        n_cmp++;
        if (q !== 8'h08 || q_bar !== 8'hF7) begin
            n_err++; $display("FAIL single_q: got q=%h qb=%h want 08/f7", q, q_bar);
        end
        n_cmp++;
        if (cmd_valid !== 1'b0) begin
            n_err++; $display("FAIL single_idle: got cmd_valid=%b want 0", cmd_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_q;
        do_reset();
        exp_q     = 8'h00;
        req_op    = 8'hFF;
        req_idx   = {3'd3, 3'd2, 3'd1, 3'd0};
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << (k % 4));
            end
            tick();
            n_cmp++;
            if (cmd_valid !== 1'b1 || cmd_gid !== 2'(k % 4)) begin
                n_err++; $display("FAIL rr_gid[%0d]: got v=%b gid=%0d want 1/%0d", k, cmd_valid, cmd_gid, k % 4);
            end
            n_cmp++;
            if (q !== exp_q) begin
                n_err++; $display("FAIL rr_q[%0d]: got %h want %h", k, q, exp_q);
            end
            exp_q = exp_q ^ (8'h01 << (k % 4));
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if (q[3:0] !== 4'h0) begin
            n_err++; $display("FAIL rr_final: got %h want 0", q[3:0]);
        end
        req_op = '0;
    endtask

    task automatic test_set_clear();
        do_reset();
        req_valid    = 4'b0100;
        req_op[5:4]  = 2'b10;
        req_idx[8:6] = 3'd5;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL sc_ready0: got %b want 0100", req_ready);
        end
        tick();
        req_op[5:4] = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100 || q[5] !== 1'b0) begin
            n_err++; $display("FAIL sc_ready1: got %b q5=%b want 0100/0", req_ready, q[5]);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (q[5] !== 1'b1) begin n_err++; $display("FAIL sc_set: got %b want 1", q[5]); end
        tick();
        n_cmp++;
        if (q[5] !== 1'b0) begin n_err++; $display("FAIL sc_clear: got %b want 0", q[5]); end
        req_op = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_op        = 8'b00_00_00_11;
        req_idx       = {3'd7, 3'd0, 3'd0, 3'd7};
        req_valid     = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_err++; $display("FAIL b2b_r0: got %b want 0001", req_ready); end
        tick();
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin n_err++; $display("FAIL b2b_r1: got %b want 1000", req_ready); end
        tick();
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (q[7] !== 1'b1 || cmd_gid !== 2'd3 || req_ready !== 4'b0001) begin
            n_err++; $display("FAIL b2b_s1: got q7=%b gid=%0d rdy=%b want 1/3/0001", q[7], cmd_gid, req_ready);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (q[7] !== 1'b1 || cmd_gid !== 2'd0) begin
            n_err++; $display("FAIL b2b_s2: got q7=%b gid=%0d want 1/0", q[7], cmd_gid);
        end
        tick();
        n_cmp++;
        if (q[7] !== 1'b0) begin n_err++; $display("FAIL b2b_s3: got %b want 0", q[7]); end
        req_op  = '0;
        req_idx = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid   = 4'b0001;
        req_op[1:0] = 2'b10;
        for (int i = 0; i < 8; i++) begin
            req_idx[2:0] = 3'(i);
            tick();
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if (q !== 8'hFF) begin n_err++; $display("FAIL mid_fill: got %h want ff", q); end
        req_op[3:2]  = 2'b11;
        req_idx[5:3] = 3'd0;
        req_valid    = 4'b0010;
        tick();
        req_valid = '0;
        n_cmp++;
        if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", cmd_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (q !== 8'h00 || cmd_valid !== 1'b0 || cmd_gid !== 2'd0) begin
            n_err++; $display("FAIL mid_reset: got q=%h v=%b gid=%0d want 00/0/0", q, cmd_valid, cmd_gid);
        end
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr: got %b want 0001", req_ready); end
        req_valid = '0;
        tick();
        n_cmp++;
        if (q !== 8'h00) begin n_err++; $display("FAIL mid_noapply: got %h want 00", q); end
        req_op  = '0;
        req_idx = '0;
    endtask

    task automatic test_err_idx();
        do_reset();
        req_valid    = 4'b0001;
        req_op[1:0]  = 2'b10;
        req_idx[2:0] = 3'd2;
        tick();
        req_idx[2:0] = 3'd7;
        tick();
        req_valid = '0;
        n_cmp++;
        if (err_idx6 !== 1'b0 || cmd_valid6 !== 1'b1 || q6 !== 6'h04) begin
            n_err++; $display("FAIL err_pre: got err=%b v=%b q=%h want 0/1/04", err_idx6, cmd_valid6, q6);
        end
        tick();
        n_cmp++;
        if (err_idx6 !== 1'b1 || q6 !== 6'h04) begin
            n_err++; $display("FAIL err_pulse: got err=%b q=%h want 1/04", err_idx6, q6);
        end
        n_cmp++;
        if (err_idx !== 1'b0) begin n_err++; $display("FAIL err_nff8: got %b want 0", err_idx); end
        tick();
        n_cmp++;
        if (err_idx6 !== 1'b0 || q6 !== 6'h04) begin
            n_err++; $display("FAIL err_end: got err=%b q=%h want 0/04", err_idx6, q6);
        end
        req_op  = '0;
        req_idx = '0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_idx   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_set_clear();
        test_back_to_back();
        test_reset_mid();
        test_err_idx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares a bank of NFF JK flip-flops between NREQ requesters.
- Each requester issues one command per handshake: hold, clear, set or toggle, aimed at one flip-flop index.
- A round-robin arbiter accepts at most one command per cycle and registers it. The command is then applied to the bank as a j/k pair on the next edge.
- The block sits between control logic (counters, sequencers) and the flip-flop state they share.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFF, 8, number of JK flip-flops in the bank (2..32).
- IDXW, $clog2(NFF), width of a flip-flop index.
- GIDW, $clog2(NREQ), width of a requester id.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op  in  2*NREQ  per-requester op, slice r = [2r+1:2r]. Encoding: 00 hold, 01 clear (j0k1), 10 set (j1k0), 11 toggle (j1k1).
- req_idx  in  IDXW*NREQ  per-requester target flip-flop index.
- q  out  NFF  flip-flop bank state.
- q_bar  out  NFF  always ~q, including during reset.
- cmd_valid  out  1  a registered command is being applied this cycle.
- cmd_gid  out  GIDW  requester id of the registered command.
- err_idx  out  1  one-cycle pulse: an accepted command had idx >= NFF.

Behaviour:
- Reset is sampled on the clk edge only. On reset:
  - q=0, q_bar=all-ones, cmd_valid=0, cmd_gid=0, err_idx=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 during the reset cycle.
- Arbitration is combinational each cycle:
  - Search starts at rr_ptr and wraps modulo NREQ.
  - The first r with req_valid[r]=1 gets req_ready[r]=1. All other ready bits are 0.
  - If no valid bit is set, req_ready=0.
- Accept = req_valid[r] & req_ready[r] at a rising edge.
  - On accept, latch op, idx and gid into the command register, set cmd_valid=1 and set rr_ptr=(r+1) mod NREQ.
  - With no accept: cmd_valid=0 and rr_ptr is unchanged.
- Requesters hold req_valid, req_op and req_idx stable until accepted. A valid drop before accept is legal and loses nothing.
- Apply stage: while cmd_valid=1, flip-flop cmd_idx receives j/k from cmd_op. All other flip-flops receive j=k=0 (hold).
- JK next-state rule:
  - 00 q holds.
  - 01 q<=0.
  - 10 q<=1.
  - 11 q<=~q.
- Latency: a command accepted at edge N is visible on q after edge N+1. Throughput is one command per cycle.
- Back-to-back commands to the same index are applied in acceptance order; two toggles return q to its original value.
- An op of 00 (hold) is still arbitrated, consumes a grant and advances rr_ptr, but does not change q.
- idx >= NFF (only possible when NFF is not a power of 2):
  - The command is accepted; err_idx pulses at the apply edge.
  - No flip-flop changes and cmd_valid still asserts.
- Reset mid-operation: a pending command register is discarded and q is cleared. Reset takes precedence over any apply on the same edge.
- Fairness: with all NREQ valid continuously, each requester is granted exactly once per NREQ cycles.

Decomposition:
- Package jk_bank_pkg holds:
  - typedef jk_op_t (2-bit enum OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE).
  - function op_to_jk returning the {j,k} pair.
- One sub-module jk_cell:
  - Ports clk, reset, j, k, q, q_bar.
  - Synchronous active-high reset to q=0.
  - Instantiated NFF times via generate.
- The round-robin arbiter stays inline; it is not split out.

Test Plan:
1. Reset, then requester 1 issues set on idx 3 -> req_ready[1]=1 at edge N; q=8'h08 and q_bar=8'hF7 after edge N+1; cmd_gid=1 during cycle N+1.
2. All 4 requesters valid continuously with toggle on idx 0..3 respectively -> grants in order 0,1,2,3,0; q bits toggle one per cycle; after 8 cycles q[3:0]=4'h0.
3. Requester 2 sets idx 5 and, next accept, clears idx 5 -> q[5] rises after edge N+1 and falls after edge N+2.
4. Requester 0 toggles idx 7 twice back-to-back while requester 3 holds idx 7 in between -> accept order 0,3,0; q[7] sequence 1,1,0.
5. Set q=8'hFF via set commands, then assert reset for one edge while a toggle is pending -> q=8'h00, cmd_valid=0 and rr_ptr=0 after that edge; the pending toggle is never applied.
6. NFF=6: requester 0 sends set with idx 7 -> accepted; err_idx=1 for one cycle; q unchanged.
